// File: rtl/mux_pkg.sv
// Shared constants for the N-channel arbitrating mux: mode encodings and
// the channel-index width helper.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // A channel index is never narrower than one bit, even for tiny N.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first valid channel after the last-granted index,
// wrapping modulo N, reported as a one-hot vector plus an index.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);

  // The search starts one past ptr, so the last winner has the lowest priority.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_arb.sv
// N-channel valid/ready mux with manual or round-robin selection feeding a
// one-entry registered output stage.
module mux_n_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   select,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int EXT = 1 << SEL_W;

  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [EXT-1:0]   valid_ext;
  logic             man_ok;
  logic [N-1:0]     man_onehot;
  logic [N-1:0]     grant_vec;
  logic [SEL_W-1:0] grant_idx;
  logic             load;
  logic             transfer;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.N(N)) u_rr (
    .valid     (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  // Zero-padding the valid vector makes an out-of-range select simply miss.
  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = in_valid;
    man_ok             = valid_ext[select];
    man_onehot         = man_ok ? (N'(1) << select) : '0;
    load               = !out_valid || out_ready;
    if (mode == MODE_RR) begin
      grant_vec = rr_any ? rr_grant : '0;
      grant_idx = rr_idx;
    end else begin
      grant_vec = man_onehot;
      grant_idx = select;
    end
    in_ready = (!rst && load) ? grant_vec : '0;
    transfer = |in_ready;
    sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];
  end

  // ptr follows every transfer regardless of mode so RR resumes fairly.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_W'(N - 1);
    end else if (load) begin
      out_valid <= transfer;
      if (transfer) begin
        out_data <= sel_data;
        out_chan <= grant_idx;
        ptr      <= grant_idx;
      end
    end
  end

endmodule

// File: doc/mux_n_arb.md
MUX_N_ARB -- requirements
Module: mux_n_arb

Interface
REQ-001 Parameter WIDTH, default 16, data width of each channel in bits (>=1).
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Derived localparam SEL_W = max(1, clog2(N)), width of channel indices.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  channel i offers a word.
REQ-008 in_ready  output  N  channel i word accepted this cycle (valid & ready = transfer).
REQ-009 mode  input  1  0 = MANUAL (select-driven), 1 = ROUND_ROBIN.
REQ-010 select  input  SEL_W  channel index used in MANUAL mode.
REQ-011 out_data  output  WIDTH  registered output word.
REQ-012 out_chan  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold a word.
REQ-014 out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-015 The block SHALL contain a one-entry output register; load = !out_valid | out_ready.
REQ-016 At most one in_ready bit SHALL be high per cycle, and only when load=1 and that channel is granted and valid.
REQ-017 MANUAL: granted channel = select when select < N and in_valid[select]=1; otherwise no grant.
REQ-018 ROUND_ROBIN: granted channel = first valid channel searching ptr+1, ptr+2, ... modulo N, where ptr is the last-granted index.
REQ-019 ptr SHALL update to the granted index only on a transfer; in MANUAL mode ptr SHALL also track transfers.
REQ-020 On a transfer the word SHALL appear on out_data, with out_chan set and out_valid=1, on the next cycle (latency 1).
REQ-021 If load=1 and no grant, out_valid SHALL go to 0 at the next edge (when out_ready consumed it) or remain 0.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold, and all in_ready SHALL be 0.
REQ-023 Simultaneous out_ready consume and new transfer in the same cycle SHALL sustain 1 word/cycle with no bubble.
REQ-024 mode/select changes SHALL affect only grants in that same cycle; a held output word SHALL be unaffected.
REQ-025 in_ready MAY depend combinationally on in_valid, mode, select and out_ready; outputs out_* SHALL be register-driven only.

Reset
REQ-026 While rst=1: out_valid=0, out_data=0, out_chan=0, in_ready=0, ptr=N-1 (channel 0 has first priority after reset).
REQ-027 Reset asserted mid-transfer SHALL discard the held word; no transfer SHALL be reported in a reset cycle.

Structure
REQ-028 Package mux_pkg SHALL hold the mode constants MODE_MANUAL=1'b0 and MODE_RR=1'b1 and the clog2-based SEL_W helper function.
REQ-029 The round-robin grant logic (valid vector + ptr -> one-hot grant + index) SHALL be a sub-module rr_arbiter, parametrised by N.
REQ-030 Datapath width SHALL be set only through WIDTH; no hard-coded 16-bit widths.

Verification (N=4, WIDTH=16 unless stated)
REQ-031 Reset: rst=1 for 2 cycles with all inputs valid -> out_valid=0, out_data=0, in_ready=0000.
REQ-032 MANUAL: select=2, in_valid=1111, in_data ch2=0xBEEF, out_ready=1 -> in_ready=0100; next cycle out_data=0xBEEF, out_chan=2.
REQ-033 ROUND_ROBIN fairness: all channels valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3, no bubbles.
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data stable, in_ready=0000; out_ready=1 -> next word is loaded in the same cycle.
REQ-035 Sparse RR: in_valid=1010 after ptr=1 -> grants ch3 then ch1; in_valid=0000 with out_ready=1 -> out_valid drops to 0.
REQ-036 Parameter sweep: N=3, WIDTH=8, MANUAL select=3 -> no grant, out_valid stays 0; RR cycles 0,1,2.
